// File: rtl/pipe_pkg.sv
// Shared encodings for the generic pipeline stage register.
// The skid-buffer occupancy states and the payload used for a flushed (bubble) entry.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        ONE   = ST_ONE,
        TWO   = ST_TWO
    } skid_state_e;

    // Replicated to the payload width by each stage; a bubble is an all-zero NOP.
    localparam logic NOP_PAYLOAD = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel around one pipeline stage register.
// "slave" is the stage's view; "master" is the surrounding pipeline's view.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 64
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with hazard HOLD/FLUSH, optional 2-entry skid
// buffer (SKID=1, registered in_ready) and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SKID  = 0,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             HOLD,
    pipe_stage_reg_if.slave  bus,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [WIDTH-1:0] NOP     = {WIDTH{NOP_PAYLOAD}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             in_ready_w;
    logic             accept;
    logic             rel;

    // HOLD masks the downstream handshake so a held payload is never released.
    assign accept = bus.in_valid & in_ready_w;
    assign rel    = out_valid_q & bus.out_ready & ~HOLD;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stall_cnt <= '0;
        end else if (((out_valid_q & ~bus.out_ready) | HOLD) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

    if (SKID == 0) begin : g_single

        assign in_ready_w = ~HOLD & (~out_valid_q | bus.out_ready);

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                out_valid_q <= 1'b0;
                out_data_q  <= NOP;
            end else if (FLUSH) begin
                out_valid_q <= 1'b0;
                out_data_q  <= NOP;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bus.in_data;
            end else if (rel) begin
                out_valid_q <= 1'b0;
                out_data_q  <= NOP;
            end
        end

    end else begin : g_skid

        skid_state_e      state_q, state_d;
        logic [WIDTH-1:0] main_d;
        logic [WIDTH-1:0] skid_q, skid_d;

        // in_ready depends only on registered state and HOLD, never on out_ready.
        assign out_valid_q = (state_q != EMPTY);
        assign in_ready_w  = ~HOLD & (state_q != TWO);

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                state_q    <= EMPTY;
                out_data_q <= NOP;
                skid_q     <= NOP;
            end else begin
                state_q    <= state_d;
                out_data_q <= main_d;
                skid_q     <= skid_d;
            end
        end

        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            main_d  = out_data_q;
            skid_d  = skid_q;
            if (FLUSH) begin
                state_d = EMPTY;
                main_d  = NOP;
                skid_d  = NOP;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            state_d = ONE;
                            main_d  = bus.in_data;
                        end
                    end
                    ONE: begin
                        if (accept && rel) begin
                            main_d = bus.in_data;
                        end else if (accept) begin
                            state_d = TWO;
                            skid_d  = bus.in_data;
                        end else if (rel) begin
                            state_d = EMPTY;
                            main_d  = NOP;
                        end
                    end
                    TWO: begin
                        // Older entry sits in main, so the skid entry moves up on release.
                        if (rel) begin
                            state_d = ONE;
                            main_d  = skid_q;
                            skid_d  = NOP;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                        main_d  = NOP;
                        skid_d  = NOP;
                    end
                endcase
            end
        end

    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (SKID=0, SKID=1, SKID=1 with a 3-bit
// counter) share stimulus and are compared against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int W  = 16;
    localparam int NV = 12;

    typedef logic [W-1:0] data_t;

    typedef struct {
        logic  fl;
        logic  ho;
        logic  iv;
        data_t id;
        logic  ordy;
        logic  exp_ov;
        data_t exp_od;
        logic  exp_ir;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        fl, ho, iv, ordy;
    data_t       idat;
    logic [15:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    int checks   = 0;
    int failures = 0;

    data_t mq[3][$];
    int    mcnt[3];
    int    cmax[3] = '{65535, 65535, 7};
    vec_t  tbl[NV];

    pipe_stage_reg_if #(.WIDTH(W)) if0 ();
    pipe_stage_reg_if #(.WIDTH(W)) if1 ();
    pipe_stage_reg_if #(.WIDTH(W)) if2 ();

    assign if0.in_valid = iv;  assign if0.in_data = idat;  assign if0.out_ready = ordy;
    assign if1.in_valid = iv;  assign if1.in_data = idat;  assign if1.out_ready = ordy;
    assign if2.in_valid = iv;  assign if2.in_data = idat;  assign if2.out_ready = ordy;

    pipe_stage_reg #(.WIDTH(W), .SKID(0), .CNT_W(16)) u_d0 (
        .CLK(CLK), .RST(RST), .FLUSH(fl), .HOLD(ho), .bus(if0), .stall_cnt(cnt0));
    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(16)) u_d1 (
        .CLK(CLK), .RST(RST), .FLUSH(fl), .HOLD(ho), .bus(if1), .stall_cnt(cnt1));
    pipe_stage_reg #(.WIDTH(W), .SKID(1), .CNT_W(3)) u_d2 (
        .CLK(CLK), .RST(RST), .FLUSH(fl), .HOLD(ho), .bus(if2), .stall_cnt(cnt2));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stage capacity: 1 entry without skid (may refill while releasing), 2 with skid.
    function automatic logic exp_ir(int i);
        if (ho) return 1'b0;
        if (i == 0) return (mq[i].size() == 0) || ordy;
        return mq[i].size() < 2;
    endfunction

    task automatic check_one(int i, logic ov, data_t od, logic ir, logic [31:0] sc);
        data_t eod;
        eod = (mq[i].size() != 0) ? mq[i][0] : '0;
        check($sformatf("d%0d_out_valid", i), 32'(ov), 32'(mq[i].size() != 0));
        check($sformatf("d%0d_out_data", i), 32'(od), 32'(eod));
        check($sformatf("d%0d_in_ready", i), 32'(ir), 32'(exp_ir(i)));
        check($sformatf("d%0d_stall_cnt", i), sc, 32'(mcnt[i]));
    endtask

    task automatic check_all();
        check_one(0, if0.out_valid, if0.out_data, if0.in_ready, 32'(cnt0));
        check_one(1, if1.out_valid, if1.out_data, if1.in_ready, 32'(cnt1));
        check_one(2, if2.out_valid, if2.out_data, if2.in_ready, 32'(cnt2));
    endtask

    task automatic model_clock();
        for (int i = 0; i < 3; i++) begin
            logic ov, ir;
            ov = (mq[i].size() != 0);
            ir = exp_ir(i);
            if (((ov && !ordy) || ho) && (mcnt[i] < cmax[i])) mcnt[i]++;
            if (fl) begin
                mq[i].delete();
            end else begin
                if (ov && ordy && !ho) void'(mq[i].pop_front());
                if (iv && ir) mq[i].push_back(idat);
            end
        end
    endtask

    task automatic drive(logic f, logic h, logic v, data_t d, logic r);
        fl = f; ho = h; iv = v; idat = d; ordy = r;
    endtask

    // Called just after a rising edge: settle, compare with the model, advance one clock.
    task automatic cycle();
        #1;
        check_all();
        model_clock();
        @(posedge CLK);
        #1;
    endtask

    // Asynchronous reset asserted between edges; outputs are checked with no clock edge.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        RST = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mcnt[i] = 0;
        end
        check_all();
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Skid-stage table: A,B,C with backpressure, FLUSH in TWO, HOLD+FLUSH together.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'h000A, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 16'h000B, 1'b0, 1'b1, 16'h000A, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b1, 16'h000A, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 16'h000A, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'h000C, 1'b1, 1'b1, 16'h000B, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h000C, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'h000D, 1'b0, 1'b1, 16'h000C, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 16'h000E, 1'b0, 1'b1, 16'h000C, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h0011, 1'b1, 1'b1, 16'h000F, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1};

        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        do_reset();

        // Back-to-back stream with a ready consumer: one-cycle latency, no stall.
        for (int k = 1; k <= 9; k++) begin
            drive(1'b0, 1'b0, k <= 8, data_t'(k), 1'b1);
            #1;
            check("t2_d0_out_data", 32'(if0.out_data), 32'(k - 1));
            check("t2_d0_in_ready", 32'(if0.in_ready), 32'd1);
            cycle();
        end

        // Load a payload, then drop RST between clock edges.
        drive(1'b0, 1'b0, 1'b1, 16'h0077, 1'b0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        #1;
        check("t1_pre_d1_out_valid", 32'(if1.out_valid), 32'd1);
        do_reset();

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].fl, tbl[k].ho, tbl[k].iv, tbl[k].id, tbl[k].ordy);
            #1;
            check($sformatf("tbl%0d_out_valid", k), 32'(if1.out_valid), 32'(tbl[k].exp_ov));
            check($sformatf("tbl%0d_out_data", k), 32'(if1.out_data), 32'(tbl[k].exp_od));
            check($sformatf("tbl%0d_in_ready", k), 32'(if1.in_ready), 32'(tbl[k].exp_ir));
            cycle();
        end

        // Saturation of the 3-bit stall counter under sustained backpressure.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 16'h0055, 1'b0);
        cycle();
        for (int j = 0; j <= 10; j++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
            #1;
            check("t6_d2_stall_cnt", 32'(cnt2), 32'((j < 7) ? j : 7));
            cycle();
        end

        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, data_t'($urandom), $urandom_range(0, 2) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
